// File: rtl/seg_pkg.sv
// Shared 7-segment code table (active-low, bit6=g .. bit0=a) and receiver FSM states.
// Pure declarations: no latency, no flow control.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sem2hex.sv
// Exact-match decode of an active-low 7-segment code to a hex nibble.
// Combinational; unknown codes give nibble 0 with match low. No flow control.
module sem2hex
    import seg_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] nib,
    output logic       match
);

    always_comb begin
        nib   = 4'h0;
        match = 1'b1;
        case (code)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'hA;
            SEG_B:   nib = 4'hB;
            SEG_C:   nib = 4'hC;
            SEG_D:   nib = 4'hD;
            SEG_E:   nib = 4'hE;
            SEG_F:   nib = 4'hF;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_rx.sv
// Serial 7-segment frame receiver: decodes DIGITS codes into a hex value.
// valid pulses one clk after the final bit is sampled; no backpressure (sender-paced).
module seg_rx
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                sdata,
    input  logic                ssel,
    output logic [4*DIGITS-1:0] value,
    output logic                valid,
    output logic                err,
    output logic                busy
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic ssel_s1, ssel_s2, ssel_d;
    logic sdata_s1, sdata_s2;

    state_t state, state_nxt;

    logic [2:0]    bit_cnt;
    logic [DW-1:0] dig_cnt;
    logic [6:0]    sh;
    logic [W-1:0]  asm_q;

    logic          sclk_rise, ssel_fall, ssel_rise;
    logic          sample, last_bit, last_dig;
    logic [6:0]    sh_nxt;
    logic [3:0]    dec_nib;
    logic          dec_match;
    logic [W-1:0]  asm_nxt;

    // Idle levels match an inactive bus so reset release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1  <= 1'b1;
            sclk_s2  <= 1'b1;
            sclk_s3  <= 1'b1;
            ssel_s1  <= 1'b1;
            ssel_s2  <= 1'b1;
            ssel_d   <= 1'b1;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            ssel_s1  <= ssel;
            ssel_s2  <= ssel_s1;
            ssel_d   <= ssel_s2;
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign ssel_fall = ssel_d & ~ssel_s2;
    assign ssel_rise = ~ssel_d & ssel_s2;
    assign sample    = (state == SHIFT) && sclk_rise && !ssel_s2;
    assign last_bit  = (bit_cnt == 3'd6);
    assign last_dig  = (dig_cnt == DW'(DIGITS - 1));

    // Decode the incoming bit together with the six already held, so the
    // seventh bit and its digit resolve in the same cycle.
    assign sh_nxt  = (sh << 1) | {6'b0, sdata_s2};
    assign asm_nxt = (asm_q << 4) | W'(dec_nib);

    sem2hex u_dec (
        .code  (sh_nxt),
        .nib   (dec_nib),
        .match (dec_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ssel_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ssel_rise)
                    state_nxt = IDLE;
                else if (sample && last_bit && last_dig)
                    state_nxt = DONE;
            end
            DONE: begin
                if (ssel_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            dig_cnt <= '0;
            sh      <= '0;
            asm_q   <= '0;
            value   <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ssel_fall) begin
                        bit_cnt <= '0;
                        dig_cnt <= '0;
                        sh      <= '0;
                        asm_q   <= '0;
                        err     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ssel_rise) begin
                        err <= 1'b1;
                    end else if (sample) begin
                        sh <= sh_nxt;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            asm_q   <= asm_nxt;
                            if (!dec_match) err <= 1'b1;
                            if (last_dig) begin
                                value <= asm_nxt;
                                valid <= 1'b1;
                            end else begin
                                dig_cnt <= dig_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (sclk_rise) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_rx.sv
// Randomized bench for seg_rx with a table-lookup reference model.
module tb_seg_rx;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int NBITS  = 7 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         sclk  = 1'b1;
    logic         sdata = 1'b0;
    logic         ssel  = 1'b1;
    logic [W-1:0] value;
    logic         valid;
    logic         err;
    logic         busy;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;

    logic [6:0]   seg_tab [16];
    logic [6:0]   frame_q [$];
    logic [W-1:0] model_value = '0;

    seg_rx #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .sclk  (sclk),
        .sdata (sdata),
        .ssel  (ssel),
        .value (value),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Counts clk cycles with valid high, so one 1-cycle pulse gives exactly 1.
    always @(negedge clk) if (valid === 1'b1) valid_cnt++;

    function automatic void model_frame(output logic [W-1:0] v, output logic e);
        int nib;
        v = '0;
        e = 1'b0;
        foreach (frame_q[d]) begin
            nib = -1;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == frame_q[d]) nib = k;
            if (nib < 0) begin
                e   = 1'b1;
                nib = 0;
            end
            v = (v << 4) | W'(nib);
        end
    endfunction

    task automatic load_hex(input logic [W-1:0] hex);
        frame_q.delete();
        for (int d = DIGITS - 1; d >= 0; d--) frame_q.push_back(seg_tab[(hex >> (4 * d)) & 4'hF]);
    endtask

    task automatic send_bit(input logic b);
        int half;
        half  = $urandom_range(4, 6) * 10;
        sclk  = 1'b0;
        sdata = b;
        #(half);
        sclk  = 1'b1;
        #(half);
    endtask

    task automatic send_bits(input int nbits);
        int n;
        n = 0;
        foreach (frame_q[d]) begin
            for (int i = 6; i >= 0; i--) begin
                if (n < nbits) begin
                    send_bit(frame_q[d][i]);
                    n++;
                end
            end
        end
    endtask

    task automatic start_frame();
        valid_cnt = 0;
        ssel = 1'b0;
        #60;
    endtask

    task automatic end_frame();
        #60;
        ssel = 1'b1;
        #100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        checks++; if (value !== '0)   begin errors++; $display("FAIL reset_value got %h want 0", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        #50;
    endtask

    task automatic test_known_frames();
        logic [6:0]   tab [3][4];
        logic [W-1:0] ev;
        logic         ee;
        tab[0] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        tab[1] = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
        tab[2] = '{7'b1111000, 7'b1111111, 7'b1111000, 7'b1111000};
        for (int f = 0; f < 3; f++) begin
            frame_q.delete();
            for (int d = 0; d < 4; d++) frame_q.push_back(tab[f][d]);
            model_frame(ev, ee);
            start_frame();
            send_bits(NBITS);
            end_frame();
            model_value = ev;
            checks++; if (value !== ev) begin errors++; $display("FAIL known%0d_value got %h want %h", f, value, ev); end
            checks++; if (err !== ee) begin errors++; $display("FAIL known%0d_err got %b want %b", f, err, ee); end
            checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL known%0d_valid_cycles got %0d want 1", f, valid_cnt); end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] ev;
        logic         ee;
        load_hex(16'h1234);
        model_frame(ev, ee);
        start_frame();
        send_bits(NBITS);
        end_frame();
        model_value = ev;
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL abort_pre_value got %h want 1234", value); end
        start_frame();
        send_bits(10);
        #60;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b want 1", busy); end
        ssel = 1'b1;
        #100;
        checks++; if (value !== model_value) begin errors++; $display("FAIL abort_value got %h want %h", value, model_value); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL abort_valid_cycles got %0d want 0", valid_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        load_hex(16'h1234);
        start_frame();
        send_bits(15);
        rst = 1'b1;
        #1;
        checks++; if (value !== '0)   begin errors++; $display("FAIL rstmid_value got %h want 0", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", valid); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL rstmid_err got %b want 0", err); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        sclk = 1'b1;
        ssel = 1'b1;
        #32;
        rst = 1'b0;
        model_value = '0;
        #50;
        load_hex(16'h0F0F);
        start_frame();
        send_bits(NBITS);
        end_frame();
        model_value = 16'h0F0F;
        checks++; if (value !== 16'h0F0F) begin errors++; $display("FAIL rstmid_next_value got %h want 0f0f", value); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_next_err got %b want 0", err); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL rstmid_next_valid_cycles got %0d want 1", valid_cnt); end
    endtask

    task automatic test_overrun();
        load_hex(16'h1234);
        start_frame();
        send_bits(NBITS);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame();
        model_value = 16'h1234;
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL overrun_value got %h want 1234", value); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL overrun_valid_cycles got %0d want 1", valid_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b want 1", err); end
    endtask

    task automatic test_random();
        logic [W-1:0] ev;
        logic         ee;
        for (int f = 0; f < 20; f++) begin
            frame_q.delete();
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 7) == 0)
                    frame_q.push_back(7'($urandom_range(0, 127)));
                else
                    frame_q.push_back(seg_tab[$urandom_range(0, 15)]);
            end
            model_frame(ev, ee);
            start_frame();
            send_bits(NBITS);
            end_frame();
            model_value = ev;
            checks++; if (value !== ev) begin errors++; $display("FAIL rand%0d_value got %h want %h", f, value, ev); end
            checks++; if (err !== ee) begin errors++; $display("FAIL rand%0d_err got %b want %b", f, err, ee); end
            checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL rand%0d_valid_cycles got %0d want 1", f, valid_cnt); end
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        test_reset();
        test_known_frames();
        test_abort();
        test_reset_mid();
        test_overrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
